// File: rtl/lvds_rx_align_ctrl.sv
// Word-alignment controller for a 9-channel LVDS receiver: resets the bitslip
// counters, then slips each channel until it sees PATTERN for MATCH_CNT words.
// Optional: define RXALIGN_AUTO_RESTART_EN to start alignment on a rising I_rx_locked in IDLE.
module lvds_rx_align_ctrl #(
  parameter logic [9:0] PATTERN    = 10'h3C5,
  parameter int         SETTLE_CYC = 8,
  parameter int         MATCH_CNT  = 16
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_rx_locked,
  input  logic [89:0] I_rx_word,
  input  logic        I_start,
  output logic [8:0]  O_cda_reset,
  output logic [8:0]  O_cda,
  output logic        O_busy,
  output logic        O_aligned,
  output logic        O_align_err,
  output logic [8:0]  O_chan_ok
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CDA_RST = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_SLIP    = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam int CW = 16;

  logic [2:0]    state_q, state_d;
  logic [3:0]    ch_q, ch_d;
  logic [3:0]    slip_q, slip_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    chan_ok_q, chan_ok_d;
  logic [9:0]    chan_word;
  logic          start_ev;

`ifdef RXALIGN_AUTO_RESTART_EN
  logic locked_q;

  // Resetting to 0 makes the first lock after reset count as a rising edge.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) locked_q <= 1'b0;
    else          locked_q <= I_rx_locked;
  end

  assign start_ev = I_start | (I_rx_locked & ~locked_q);
`else
  assign start_ev = I_start;
`endif

  always_comb begin
    chan_word = '0;
    for (int n = 0; n < 9; n++) begin
      if (ch_q == 4'(n)) chan_word = I_rx_word[n*10 +: 10];
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    ch_d      = ch_q;
    slip_d    = slip_q;
    cnt_d     = cnt_q;
    chan_ok_d = chan_ok_q;

    if (!I_rx_locked) begin
      // Lock loss overrides everything except IDLE, which is already clean.
      state_d   = S_IDLE;
      ch_d      = '0;
      slip_d    = '0;
      cnt_d     = '0;
      chan_ok_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            state_d = S_CDA_RST;
            cnt_d   = '0;
          end
        end
        S_CDA_RST: begin
          ch_d      = '0;
          slip_d    = '0;
          chan_ok_d = '0;
          if (cnt_q == CW'(1)) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_d = S_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (chan_word != PATTERN) begin
            state_d = S_SLIP;
            cnt_d   = '0;
          end else if (cnt_q == CW'(MATCH_CNT - 1)) begin
            state_d = S_NEXT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SLIP: begin
          if (slip_q == 4'd9) begin
            state_d = S_ERR;
          end else begin
            slip_d  = slip_q + 4'd1;
            state_d = S_SETTLE;
            cnt_d   = '0;
          end
        end
        S_NEXT: begin
          chan_ok_d = chan_ok_q | (9'd1 << ch_q);
          if (ch_q == 4'd8) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 4'd1;
            slip_d  = '0;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
        S_DONE, S_ERR: begin
          // Flags are cleared on entry so CDA_RST never shows stale results.
          if (start_ev) begin
            state_d   = S_CDA_RST;
            cnt_d     = '0;
            chan_ok_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      slip_q    <= '0;
      cnt_q     <= '0;
      chan_ok_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      ch_q      <= ch_d;
      slip_q    <= slip_d;
      cnt_q     <= cnt_d;
      chan_ok_q <= chan_ok_d;
    end
  end

  // Pulses are gated by lock so a lock-loss cycle never emits a partial slip/reset.
  assign O_cda_reset = (state_q == S_CDA_RST && I_rx_locked) ? 9'h1FF : 9'h000;
  assign O_cda       = (state_q == S_SLIP && slip_q != 4'd9 && I_rx_locked) ? (9'd1 << ch_q) : 9'h000;
  assign O_busy      = (state_q == S_CDA_RST) || (state_q == S_SETTLE) || (state_q == S_CHECK) ||
                       (state_q == S_SLIP) || (state_q == S_NEXT);
  assign O_aligned   = (state_q == S_DONE);
  assign O_align_err = (state_q == S_ERR);
  assign O_chan_ok   = chan_ok_q;

endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Self-checking bench for lvds_rx_align_ctrl: an emulated deserialiser reacts to the
// bitslip pulses, and a phase-sequence model predicts every output cycle by cycle.
module tb_lvds_rx_align_ctrl;

  localparam logic [9:0] PATTERN    = 10'h3C5;
  localparam int         SETTLE_CYC = 8;
  localparam int         MATCH_CNT  = 16;
  localparam int         NEVER      = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_locked;
  logic [89:0] rx_word;
  logic        start;
  logic [8:0]  cda_reset, cda, chan_ok;
  logic        busy, aligned, align_err;

  lvds_rx_align_ctrl #(
    .PATTERN(PATTERN), .SETTLE_CYC(SETTLE_CYC), .MATCH_CNT(MATCH_CNT)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_rx_locked(rx_locked), .I_rx_word(rx_word),
    .I_start(start), .O_cda_reset(cda_reset), .O_cda(cda), .O_busy(busy),
    .O_aligned(aligned), .O_align_err(align_err), .O_chan_ok(chan_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       aligned;
    logic       err;
    logic [8:0] cdar;
    logic [8:0] cda;
    logic [8:0] ok;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Channel emulation: slips needed per channel (NEVER = no bit position works).
  int   k     [9];
  int   slips [9];

  // Expected-output timeline of one alignment run, indexed from the first CDA_RST cycle.
  exp_t trace[$];
  bit   active      = 0;
  int   pos         = 0;
  logic prev_locked = 1'b0;
  int   start_cyc   = 0;

  // Observations of the DUT over one scenario.
  int   pulses [9];
  int   last_p [9];
  int   min_gap[9];
  int   cdar_cycles;
  int   first_al;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] dut_pack();
    exp_t a;
    a = '{busy, aligned, align_err, cda_reset, cda, chan_ok};
    return 32'(a);
  endfunction

  // Builds the run as a sequence of phases: 2 reset cycles, then per channel
  // (settle, 1-cycle failed check, slip) repeated until the right slip count,
  // then settle, full check, channel-done cycle.
  task automatic build_trace();
    logic [8:0] ok;
    exp_t e;
    trace.delete();
    ok = '0;
    repeat (2) begin e = '{1'b1, 1'b0, 1'b0, 9'h1FF, 9'h000, 9'h000}; trace.push_back(e); end
    for (int n = 0; n < 9; n++) begin
      for (int s = 0; ; s++) begin
        repeat (SETTLE_CYC) begin e = '{1'b1, 1'b0, 1'b0, 9'h0, 9'h0, ok}; trace.push_back(e); end
        if (s == k[n]) begin
          repeat (MATCH_CNT + 1) begin e = '{1'b1, 1'b0, 1'b0, 9'h0, 9'h0, ok}; trace.push_back(e); end
          ok[n] = 1'b1;
          break;
        end
        e = '{1'b1, 1'b0, 1'b0, 9'h0, 9'h0, ok}; trace.push_back(e);
        if (s == 9) begin
          trace.push_back(e);
          e = '{1'b0, 1'b0, 1'b1, 9'h0, 9'h0, ok}; trace.push_back(e);
          return;
        end
        e = '{1'b1, 1'b0, 1'b0, 9'h0, 9'(1 << n), ok}; trace.push_back(e);
      end
    end
    e = '{1'b0, 1'b1, 1'b0, 9'h0, 9'h0, ok};
    trace.push_back(e);
  endtask

  task automatic model_edge(input logic busy_now);
    logic sev;
    sev = start;
`ifdef RXALIGN_AUTO_RESTART_EN
    if (!active && rx_locked && !prev_locked) sev = 1'b1;
`endif
    if (active && !rx_locked) begin
      active = 0;
    end else if (rx_locked && sev && !busy_now) begin
      build_trace();
      active    = 1;
      pos       = 0;
      start_cyc = cyc + 1;
    end else if (active && pos < trace.size() - 1) begin
      pos++;
    end
    prev_locked = rx_locked;
  endtask

  task automatic emulate(input logic [8:0] p_cda, input logic [8:0] p_cdar);
    logic [89:0] w;
    logic [9:0]  g;
    for (int n = 0; n < 9; n++) begin
      if (p_cdar[n])     slips[n] = 0;
      else if (p_cda[n]) slips[n]++;
      g = 10'($urandom_range(0, 1023));
      if (g == PATTERN) g = g ^ 10'h001;
      w[n*10 +: 10] = (slips[n] == k[n]) ? PATTERN : g;
    end
    rx_word = w;
  endtask

  task automatic clear_stats();
    for (int n = 0; n < 9; n++) begin pulses[n] = 0; last_p[n] = -1; min_gap[n] = 1 << 30; end
    cdar_cycles = 0;
    first_al    = -1;
  endtask

  // One clock cycle: compare at the falling edge, then drive new inputs 1ns after the rising edge.
  task automatic step();
    exp_t       e;
    logic [8:0] c_cda, c_cdar;
    @(negedge clk);
    e = active ? trace[pos] : '0;
    if (!rx_locked) begin e.cda = '0; e.cdar = '0; end
    check("cycle_outputs", dut_pack(), 32'(e));
    for (int n = 0; n < 9; n++) begin
      if (cda[n]) begin
        pulses[n]++;
        if (last_p[n] >= 0 && cyc - last_p[n] < min_gap[n]) min_gap[n] = cyc - last_p[n];
        last_p[n] = cyc;
      end
    end
    if (cda_reset != 9'h0) cdar_cycles++;
    if (aligned && first_al < 0) first_al = cyc;
    c_cda  = cda;
    c_cdar = cda_reset;
    model_edge(e.busy);
    @(posedge clk);
    #1;
    emulate(c_cda, c_cdar);
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_end();
    int guard = 0;
    while (active && pos < trace.size() - 1 && guard < 20000) begin step(); guard++; end
    repeat (3) step();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", dut_pack(), 32'h0);
    active      = 0;
    prev_locked = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int sum_pulses();
    int s = 0;
    for (int n = 0; n < 9; n++) s += pulses[n];
    return s;
  endfunction

  initial begin
    rst_n     = 1'b0;
    rx_locked = 1'b0;
    start     = 1'b0;
    for (int n = 0; n < 9; n++) begin k[n] = 0; slips[n] = 0; end
    emulate('0, '0);
    #2;
    check("reset_outputs", dut_pack(), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();

    // Lock rises without I_start.
    rx_locked = 1'b1;
    repeat (4) step();
`ifdef RXALIGN_AUTO_RESTART_EN
    check("lock_rise_busy", 32'(busy), 32'h1);
`else
    check("lock_rise_busy", 32'(busy), 32'h0);
`endif
    run_to_end();

    // All channels already aligned.
    clear_stats();
    pulse_start();
    run_to_end();
    check_range("all_ok_latency", first_al - start_cyc, 225, 229);
    check("all_ok_cdar_cycles", 32'(cdar_cycles), 32'd2);
    check("all_ok_cda_pulses", 32'(sum_pulses()), 32'd0);
    check("all_ok_aligned", 32'(aligned), 32'h1);
    check("all_ok_chan_ok", 32'(chan_ok), 32'h1FF);

    // Channel 3 needs four slips.
    k[3] = 4;
    clear_stats();
    pulse_start();
    run_to_end();
    check("ch3_pulses", 32'(pulses[3]), 32'd4);
    check("ch3_total_pulses", 32'(sum_pulses()), 32'd4);
    check("ch3_gap_ge8", 32'(min_gap[3] >= 8), 32'h1);
    check("ch3_chan_ok", 32'(chan_ok), 32'h1FF);
    check("ch3_aligned", 32'(aligned), 32'h1);

    // Channel 5 never matches.
    k[3] = 0;
    k[5] = NEVER;
    clear_stats();
    pulse_start();
    run_to_end();
    check("ch5_pulses", 32'(pulses[5]), 32'd9);
    check("ch5_align_err", 32'(align_err), 32'h1);
    check("ch5_chan_ok", 32'(chan_ok), 32'h01F);
    check("ch5_busy", 32'(busy), 32'h0);
    check("ch5_aligned", 32'(aligned), 32'h0);

    // Lock lost during the channel-2 check window (cycles 60..75 of the run).
    k[5] = 0;
    pulse_start();
    while (active && pos < 65) step();
    rx_locked = 1'b0;
    step();
    check("lock_loss_outputs", dut_pack(), 32'h0);
    step();
    rx_locked = 1'b1;
    step();
    pulse_start();
    run_to_end();
    check("relock_aligned", 32'(aligned), 32'h1);
    check("relock_chan_ok", 32'(chan_ok), 32'h1FF);

    // Randomised runs: random slip needs, idle gaps, ignored starts, lock loss, async reset.
    for (int r = 0; r < 10; r++) begin
      int  mode;
      bit  any_never;
      any_never = 0;
      for (int n = 0; n < 9; n++) begin
        int v = $urandom_range(0, 11);
        k[n] = (v > 9) ? NEVER : v;
        if (k[n] == NEVER) any_never = 1;
      end
      repeat ($urandom_range(1, 5)) step();
      pulse_start();
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        repeat ($urandom_range(5, 150)) step();
        pulse_start();
      end else if (mode == 2) begin
        repeat ($urandom_range(3, 300)) step();
        rx_locked = 1'b0;
        repeat ($urandom_range(1, 4)) step();
        rx_locked = 1'b1;
        step();
        pulse_start();
      end else if (mode == 3) begin
        repeat ($urandom_range(3, 300)) step();
        async_reset();
        step();
        pulse_start();
      end
      run_to_end();
      check("rand_final_aligned", 32'(aligned), 32'(!any_never));
      check("rand_final_err", 32'(align_err), 32'(any_never));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_rx_align_ctrl.md
LVDS_RX_ALIGN_CTRL -- requirements
Module: lvds_rx_align_ctrl

Interface
REQ-001 SHALL provide parameter PATTERN, default 10'h3C5, the per-channel training word.
REQ-002 SHALL provide parameter SETTLE_CYC, default 8, the wait cycles after any cda_reset/cda pulse.
REQ-003 SHALL provide parameter MATCH_CNT, default 16, the consecutive matching words required per channel.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 I_clk  in  1  rx_outclock domain; all logic rising-edge.
REQ-006 I_rst_n  in  1  asynchronous active-low reset.
REQ-007 I_rx_locked  in  1  LVDS PLL lock, synchronous to I_clk.
REQ-008 I_rx_word  in  90  deserialised words; channel n = [10n+9:10n].
REQ-009 I_start  in  1  single-cycle request to (re)align.
REQ-010 O_cda_reset  out  9  per-channel bitslip-counter reset.
REQ-011 O_cda  out  9  per-channel bitslip pulse.
REQ-012 O_busy  out  1  alignment in progress.
REQ-013 O_aligned  out  1  all 9 channels aligned.
REQ-014 O_align_err  out  1  a channel failed alignment.
REQ-015 O_chan_ok  out  9  per-channel aligned flags.

Function
REQ-016 SHALL implement states IDLE, CDA_RST, SETTLE, CHECK, SLIP, NEXT, DONE, ERR.
REQ-017 IDLE: I_start=1 with I_rx_locked=1 -> CDA_RST next cycle; I_start with I_rx_locked=0 is ignored.
REQ-018 CDA_RST: O_cda_reset=9'h1FF for exactly 2 cycles; clear O_chan_ok, O_aligned, O_align_err; ch=0, slip=0; -> SETTLE.
REQ-019 SETTLE: wait exactly SETTLE_CYC cycles -> CHECK with match counter cleared.
REQ-020 CHECK: I_rx_word[ch]==PATTERN increments match counter; MATCH_CNT consecutive matches -> NEXT; any mismatch -> SLIP.
REQ-021 SLIP: if slip==9, set O_align_err, -> ERR; otherwise pulse O_cda[ch] exactly 1 cycle (one-hot, other bits 0), slip++, -> SETTLE.
REQ-022 NEXT: set O_chan_ok[ch]; if ch==8 -> DONE, else ch++, slip=0, -> SETTLE.
REQ-023 DONE: O_aligned=1, O_busy=0; I_start -> CDA_RST.
REQ-024 ERR: O_busy=0, O_chan_ok retains passed channels; I_start -> CDA_RST.
REQ-025 O_busy=1 in CDA_RST, SETTLE, CHECK, SLIP, NEXT only.
REQ-026 I_start while O_busy=1 SHALL be ignored.
REQ-027 I_rx_locked=0 in any state except IDLE -> IDLE next cycle, clearing O_aligned, O_chan_ok, O_align_err, counters; cda outputs 0 that cycle.
REQ-028 At most one O_cda bit high per cycle; O_cda and O_cda_reset never high together.
REQ-029 Total slips per channel bounded to 9 (10 bit positions tried).

Reset
REQ-030 On I_rst_n=0: state IDLE, all outputs 0, ch/slip/settle/match counters 0, asynchronously.
REQ-031 Reset deassertion mid-alignment SHALL restart from IDLE; no partial pulse SHALL be emitted.

Configuration
REQ-032 Macro RXALIGN_AUTO_RESTART_EN defined: a rising edge of I_rx_locked (including first lock after reset) in IDLE SHALL start alignment as if I_start were asserted.
REQ-033 Macro undefined: alignment starts only on I_start; rising I_rx_locked alone leaves state IDLE.

Verification
REQ-034 Reset, lock=1, all channels drive 10'h3C5, pulse I_start -> O_cda_reset=1FF 2 cycles, zero O_cda pulses, O_aligned=1 after 2+9*(8+16+1) cycles +/-2.
REQ-035 Channel 3 model needs 4 slips -> exactly 4 single-cycle O_cda[3] pulses, each >=8 cycles apart, O_chan_ok=1FF, O_aligned=1.
REQ-036 Channel 5 never matches -> 9 O_cda[5] pulses, O_align_err=1, O_chan_ok=9'h01F, O_busy=0.
REQ-037 Drop I_rx_locked during channel 2 CHECK -> IDLE next cycle, all outputs 0; restart with I_start succeeds.
REQ-038 With RXALIGN_AUTO_RESTART_EN: lock 0->1 without I_start -> CDA_RST next cycle; without macro -> remains IDLE.
